// File: rtl/clu_pkg.sv
// Shared definitions for the combinational logic unit: the default truth
// table, the default counter width and the table lookup helper.
package clu_pkg;

    // Index type for the three function inputs packed as {A,B,C}.
    typedef logic [2:0] clu_idx_t;

    // Odd parity of three inputs: bits 1, 2, 4 and 7 set.
    localparam logic [7:0] PARITY_TT = 8'h96;

    // Default width of the high-cycle counter.
    localparam int DEFAULT_CNT_W = 8;

    // Pick one bit of an 8-entry truth table. An X/Z index yields X,
    // so unknown inputs are never silently masked.
    function automatic logic clu_lookup(input logic [7:0] tt, input clu_idx_t idx);
        return tt[idx];
    endfunction

endpackage

// File: rtl/clu_edge_cnt.sv
// Registered side-path of the logic unit: a one-cycle copy of F, a rising
// edge pulse and a saturating count of cycles in which F was sampled high.
module clu_edge_cnt
    import clu_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             f_i,
    output logic             f_q_o,
    output logic             rise_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             fQ;
    logic             fD;
    logic             riseQ;
    logic             riseD;
    logic [CNT_W-1:0] cntQ;
    logic [CNT_W-1:0] cntD;

    // Next-state logic: the pulse compares the incoming sample against the
    // previous one, and the counter holds once it reaches all-ones.
    always_comb begin
        fD    = f_i;
        riseD = f_i & ~fQ;
        cntD  = cntQ;
        if (f_i && (cntQ != CNT_MAX)) begin
            cntD = cntQ + CNT_ONE;
        end
    end

    // State registers; reset takes priority over the sample and increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fQ    <= 1'b0;
            riseQ <= 1'b0;
            cntQ  <= '0;
        end else begin
            fQ    <= fD;
            riseQ <= riseD;
            cntQ  <= cntD;
        end
    end

    assign f_q_o  = fQ;
    assign rise_o = riseQ;
    assign cnt_o  = cntQ;

endmodule

// File: rtl/combinational_logic_unit.sv
// Three-input Boolean function unit. F is a pure table lookup of {A,B,C}
// with no dependence on clock or reset; the registered copy, rise pulse
// and high-cycle counter live in clu_edge_cnt.
module combinational_logic_unit
    import clu_pkg::*;
#(
    parameter logic [7:0] TRUTH_TABLE = PARITY_TT,
    parameter int         CNT_W       = DEFAULT_CNT_W
) (
    input  logic             A,
    input  logic             B,
    input  logic             C,
    output logic             F,
    input  logic             clk,
    input  logic             rst,
    output logic             F_q,
    output logic             f_rise,
    output logic [CNT_W-1:0] hi_cnt
);

    clu_idx_t idx;

    // Instant decode: A is the index MSB, C the LSB.
    always_comb begin
        idx = {A, B, C};
        F   = clu_lookup(TRUTH_TABLE, idx);
    end

    clu_edge_cnt #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .f_i    (F),
        .f_q_o  (F_q),
        .rise_o (f_rise),
        .cnt_o  (hi_cnt)
    );

endmodule

// File: tb/tb_combinational_logic_unit.sv
// Testbench for combinational_logic_unit: checks the instant decode for the
// default and an AND-style table, and the registered side-path against a
// small reference model through an expectation queue.
module tb_combinational_logic_unit;

    typedef struct {
        string      tag;
        logic       fq;
        logic       rise;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a   = 1'b0;
    logic b   = 1'b0;
    logic c   = 1'b0;

    logic       fPar;
    logic       fqPar;
    logic       risePar;
    logic [7:0] cntPar;

    logic       fAnd;
    logic       fqAnd;
    logic       riseAnd;
    logic [7:0] cntAnd;

    logic       fSat;
    logic       fqSat;
    logic       riseSat;
    logic [1:0] cntSat;

    logic       fNoClk;
    logic       fqNoClk;
    logic       riseNoClk;
    logic [7:0] cntNoClk;

    int checks   = 0;
    int failures = 0;

    exp_t expQ[$];

    logic       mFq   = 1'b0;
    logic       mRise = 1'b0;
    int         mCnt  = 0;
    int         mCnt2 = 0;

    always #5 clk = ~clk;

    // Default parity table, 8-bit counter.
    combinational_logic_unit dutPar (
        .A(a), .B(b), .C(c), .F(fPar),
        .clk(clk), .rst(rst),
        .F_q(fqPar), .f_rise(risePar), .hi_cnt(cntPar)
    );

    // Three-input AND table.
    combinational_logic_unit #(.TRUTH_TABLE(8'h80)) dutAnd (
        .A(a), .B(b), .C(c), .F(fAnd),
        .clk(clk), .rst(rst),
        .F_q(fqAnd), .f_rise(riseAnd), .hi_cnt(cntAnd)
    );

    // Parity table with a 2-bit counter for saturation.
    combinational_logic_unit #(.CNT_W(2)) dutSat (
        .A(a), .B(b), .C(c), .F(fSat),
        .clk(clk), .rst(rst),
        .F_q(fqSat), .f_rise(riseSat), .hi_cnt(cntSat)
    );

    // Clock and reset held static: only the decode is meaningful here.
    combinational_logic_unit dutNoClk (
        .A(a), .B(b), .C(c), .F(fNoClk),
        .clk(1'b0), .rst(1'b0),
        .F_q(fqNoClk), .f_rise(riseNoClk), .hi_cnt(cntNoClk)
    );

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkVec(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, check the decode, and queue what the
    // registered outputs must show after the next rising edge.
    task automatic applyStimulus(input logic ai, input logic bi, input logic ci,
                                 input logic ri, input string tag);
        logic f;
        exp_t e;
        a   = ai;
        b   = bi;
        c   = ci;
        rst = ri;
        #1;
        f = ai ^ bi ^ ci;
        checkBit({tag, ".F"},    fPar, f);
        checkBit({tag, ".Fand"}, fAnd, ai & bi & ci);
        if (ri) begin
            mFq = 1'b0; mRise = 1'b0; mCnt = 0; mCnt2 = 0;
        end else begin
            mRise = f & ~mFq;
            mFq   = f;
            if (f && mCnt < 255) mCnt++;
            if (f && mCnt2 < 3)  mCnt2++;
        end
        e.tag  = tag;
        e.fq   = mFq;
        e.rise = mRise;
        e.cnt  = 8'(mCnt);
        e.cnt2 = 2'(mCnt2);
        expQ.push_back(e);
    endtask

    // Let the edge happen, then compare registered outputs with the queue head.
    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        assert (expQ.size() > 0) else begin
            failures++;
            $error("[TB] FAIL queue observed=empty expected=entry");
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkBit({e.tag, ".F_q"},    fqPar,       e.fq);
            checkBit({e.tag, ".f_rise"}, risePar,     e.rise);
            checkVec({e.tag, ".hi_cnt"}, cntPar,      e.cnt);
            checkVec({e.tag, ".sat"},    {6'd0, cntSat}, {6'd0, e.cnt2});
        end
    endtask

    task automatic step(input logic [2:0] abc, input logic ri, input string tag);
        applyStimulus(abc[2], abc[1], abc[0], ri, tag);
        checkOutput();
    endtask

    initial begin
        // Decode with no clock activity at all.
        a = 1'b1; b = 1'b0; c = 1'b0;
        #5;
        checkBit("noclk.F", fNoClk, 1'b1);
        checkBit("noclk.Fpar", fPar, 1'b1);
        @(posedge clk);
        #1;

        // Reset held while sweeping every input combination.
        for (int i = 0; i < 8; i++) begin
            step(3'(i), 1'b1, $sformatf("sweep%0d", i));
        end

        // Release reset and hold ABC=100 long enough to saturate CNT_W=2.
        for (int i = 1; i <= 6; i++) begin
            step(3'b100, 1'b0, $sformatf("hold%0d", i));
        end

        // F drops, then rises again through a different input pattern.
        step(3'b000, 1'b0, "low");
        step(3'b111, 1'b0, "rise2");
        step(3'b011, 1'b0, "low2");

        // Mid-count reset: count to 2, then reset while F stays 1.
        step(3'b000, 1'b1, "rstA");
        step(3'b010, 1'b0, "cnt1");
        step(3'b001, 1'b0, "cnt2");
        step(3'b100, 1'b1, "midrst");
        checkBit("midrst.Fheld", fPar, 1'b1);
        step(3'b100, 1'b0, "release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
